// File: rtl/seq_alu.sv
// Registered EX-stage ALU with multi-cycle shift-add MULU and restoring DIVU.
// Define SEQ_ALU_OVF_EN to add the signed-overflow output ovf for ADD/SUB.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
`ifdef SEQ_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   y_hi_q, y_hi_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   add_r;
    logic [WIDTH-1:0]   sub_r;
    logic [WIDTH-1:0]   sc_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_nxt;

    assign add_r = a + b;
    assign sub_r = a - b;

    always_comb begin
        sc_res = '0;
        case (alu_ctrl)
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_ADD:  sc_res = add_r;
            OP_SUB:  sc_res = sub_r;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
            default: sc_res = '0;
        endcase
    end

    // MUL: acc = {partial product, remaining multiplier}; carry enters the shift.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        if (acc_q[0]) begin
            mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            mul_nxt = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    // DIV: acc = {remainder, dividend/quotient}; one restoring step per cycle.
    always_comb begin
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = rem_sh - {1'b0, opb_q};
        if (!div_diff[WIDTH]) begin
            div_nxt = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        zero_d  = zero_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (alu_ctrl == OP_MULU) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        opb_d   = a;
                    end else if (alu_ctrl == OP_DIVU) begin
                        if (b == '0) begin
                            y_d    = '1;
                            y_hi_d = a;
                            zero_d = 1'b0;
                            dbz_d  = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            state_d = DIV;
                            cnt_d   = '0;
                            acc_d   = {{WIDTH{1'b0}}, a};
                            opb_d   = b;
                        end
                    end else begin
                        y_d    = sc_res;
                        y_hi_d = '0;
                        zero_d = (sc_res == '0);
                        dbz_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_nxt : div_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    y_d     = acc_d[WIDTH-1:0];
                    y_hi_d  = acc_d[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_d[WIDTH-1:0] == '0);
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            y_q     <= '0;
            y_hi_q  <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef SEQ_ALU_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_add, ovf_sub;

    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && start) begin
            case (alu_ctrl)
                OP_ADD:  ovf_d = ovf_add;
                OP_SUB:  ovf_d = ovf_sub;
                default: ovf_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign y           = y_q;
    assign y_hi        = y_hi_q;
    assign zero        = zero_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): single-cycle ops, MULU/DIVU latency,
// divide-by-zero, ignored start while busy, async reset abort, optional ovf.
module tb_seq_alu;

    localparam logic [2:0] AND_ = 3'b000;
    localparam logic [2:0] OR_  = 3'b001;
    localparam logic [2:0] ADD_ = 3'b010;
    localparam logic [2:0] MULU = 3'b011;
    localparam logic [2:0] DIVU = 3'b100;
    localparam logic [2:0] SLTU = 3'b101;
    localparam logic [2:0] SUB_ = 3'b110;
    localparam logic [2:0] SLT_ = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  alu_ctrl;
    logic [31:0] a, b;
    logic [31:0] y, y_hi;
    logic        zero, busy, done, div_by_zero;
`ifdef SEQ_ALU_OVF_EN
    logic        ovf;
`endif

    int n_vec = 0;
    int n_err = 0;
    int k;
    int bc;
    int nd;
    logic [31:0] y_prev;

    seq_alu dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .alu_ctrl(alu_ctrl),
        .a(a),
        .b(b),
        .y(y),
        .y_hi(y_hi),
        .zero(zero),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
`ifdef SEQ_ALU_OVF_EN
        ,
        .ovf(ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves start low at the next negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        start    = 1'b1;
        alu_ctrl = op;
        a        = va;
        b        = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // From the first negedge after the start edge, wait for done (bounded).
    task automatic wait_done(input bit inject, output int kk, output int busy_n);
        kk = 1;
        busy_n = 0;
        while (!done && kk < 40) begin
            busy_n += int'(busy);
            if (kk == 10) chk("hold_y_busy", y, y_prev);
            start = 1'b0;
            if (inject && kk == 5) begin
                start    = 1'b1;
                alu_ctrl = ADD_;
                a        = 32'h1;
                b        = 32'h1;
            end
            @(negedge clk);
            kk++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        alu_ctrl = '0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst_y", y, 32'h0);
        chk("rst_bits", {27'h0, zero, busy, done, div_by_zero, 1'b0}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(SUB_, 32'h29, 32'h08);
        chk("sub_y", y, 32'h21);
        chk("sub_flags", {28'h0, zero, done, div_by_zero, busy}, {28'h0, 4'b0100});
        chk("sub_yhi", y_hi, 32'h0);
        issue(SUB_, 32'h08, 32'h08);
        chk("sub0_y", y, 32'h0);
        chk("sub0_zero", {31'h0, zero}, 32'h1);
        issue(ADD_, 32'h29, 32'h08);
        chk("add_y", y, 32'h31);
        chk("add_zero", {31'h0, zero}, 32'h0);
        issue(AND_, 32'hF0F0, 32'hFF00);
        chk("and_y", y, 32'hF000);
        issue(OR_, 32'h0F, 32'hF0);
        chk("or_y", y, 32'hFF);
        issue(SLT_, 32'hFFFFFFFD, 32'hFFFFFFFB);
        chk("slt_a", y, 32'h0);
        issue(SLTU, 32'hFFFFFFFD, 32'hFFFFFFFB);
        chk("sltu_a", y, 32'h0);
        issue(SLT_, 32'hFFFFFFFB, 32'hFFFFFFFD);
        chk("slt_b", y, 32'h1);
        issue(SLT_, 32'h1, 32'hFFFFFFFF);
        chk("slt_c", y, 32'h0);
        issue(SLTU, 32'h1, 32'hFFFFFFFF);
        chk("sltu_c", y, 32'h1);
        chk("sltu_done", {31'h0, done}, 32'h1);
        @(negedge clk);
        chk("done_pulse", {31'h0, done}, 32'h0);
        chk("hold_y", y, 32'h1);

        y_prev = 32'h1;
        issue(MULU, 32'hFFFFFFFF, 32'h2);
        chk("mul_busy0", {30'h0, busy, done}, 32'h2);
        wait_done(1'b1, k, bc);
        chk("mul_latency", k, 33);
        chk("mul_busy_cycles", bc, 32);
        chk("mul_y", y, 32'hFFFFFFFE);
        chk("mul_yhi", y_hi, 32'h1);
        chk("mul_flags", {28'h0, zero, done, div_by_zero, busy}, {28'h0, 4'b0100});

        y_prev = 32'hFFFFFFFE;
        issue(DIVU, 32'd100, 32'd7);
        wait_done(1'b0, k, bc);
        chk("div_latency", k, 33);
        chk("div_y", y, 32'd14);
        chk("div_yhi", y_hi, 32'd2);
        chk("div_dbz", {31'h0, div_by_zero}, 32'h0);

        // Back-to-back: start in the done cycle.
        issue(DIVU, 32'h55, 32'h0);
        chk("dbz_y", y, 32'hFFFFFFFF);
        chk("dbz_yhi", y_hi, 32'h55);
        chk("dbz_flags", {28'h0, zero, done, div_by_zero, busy}, {28'h0, 4'b0110});
        @(negedge clk);
        chk("dbz_hold", {30'h0, done, div_by_zero}, 32'h1);

        issue(MULU, 32'h3, 32'h5);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_y", y, 32'h0);
        chk("arst_yhi", y_hi, 32'h0);
        chk("arst_bits", {28'h0, zero, busy, done, div_by_zero}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            nd += int'(done) + int'(busy);
        end
        chk("no_done_after_rst", nd, 0);
        issue(ADD_, 32'h29, 32'h08);
        chk("post_rst_add", y, 32'h31);
        chk("post_rst_done", {31'h0, done}, 32'h1);

`ifdef SEQ_ALU_OVF_EN
        issue(ADD_, 32'h7FFFFFFF, 32'h1);
        chk("ovf_add_y", y, 32'h80000000);
        chk("ovf_add", {31'h0, ovf}, 32'h1);
        issue(SUB_, 32'h80000000, 32'h1);
        chk("ovf_sub", {31'h0, ovf}, 32'h1);
        issue(ADD_, 32'h1, 32'h1);
        chk("ovf_none", {31'h0, ovf}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds unsigned SLTU, multi-cycle unsigned multiply (shift-add) and unsigned divide (restoring) behind a start/busy/done handshake.
- Sits in the EX stage of the multi-cycle datapath; the controller holds the stage while busy is high.
- Single-cycle ops complete in 1 clock; MULU/DIVU take WIDTH+1 clocks.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only when busy=0.
- alu_ctrl  input  3  op select, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- y  output  WIDTH  result (MULU low half, DIVU quotient).
- y_hi  output  WIDTH  MULU high half / DIVU remainder; 0 for other ops.
- zero  output  1  1 when y==0; registered together with y.
- busy  output  1  high while a MULU/DIVU is iterating.
- done  output  1  one-cycle pulse when y/y_hi/zero are updated.
- div_by_zero  output  1  set with done when DIVU had b==0; otherwise 0.

Behaviour:
- alu_ctrl encodings: AND=000, OR=001, ADD=010, MULU=011, DIVU=100, SLTU=101, SUB=110, SLT=111.
- Reset (async assert, sync-release use): state=IDLE; y, y_hi, zero, busy, done, div_by_zero, counter and internal regs all 0. Reset mid-operation aborts it; no done is produced.
- States: IDLE, MUL, DIV.
- IDLE + start + single-cycle op:
  - Result registered at the next edge; done=1 that cycle; stay IDLE.
  - Latency is 1.
- Single-cycle op results:
  - ADD/SUB: modulo 2^WIDTH.
  - SLT: signed compare, y={0..,1} if a<b signed.
  - SLTU: unsigned compare.
  - AND/OR: bitwise.
  - y_hi=0 and div_by_zero=0 for all of these.
- IDLE + start + MULU:
  - Latch a, b; counter=0; go to MUL with busy=1.
  - Each cycle: if multiplier LSB=1, add multiplicand into the 2*WIDTH accumulator high half; shift right one.
  - After WIDTH iterations: {y_hi,y}=a*b (unsigned, 2*WIDTH bits), done=1, busy=0, back to IDLE.
  - done asserts exactly WIDTH+1 edges after the start edge.
- IDLE + start + DIVU, b!=0:
  - Go to DIV with busy=1.
  - Each cycle is one restoring step: shift remainder:dividend left; trial-subtract divisor; keep if non-negative and set quotient bit.
  - After WIDTH iterations: y=a/b, y_hi=a%b, done=1, back to IDLE. Same latency as MULU.
- DIVU with b==0:
  - No iteration; next edge y={WIDTH{1}}, y_hi=a, div_by_zero=1, done=1; stay IDLE.
  - Latency is 1.
- start while busy=1: ignored; operands and alu_ctrl are not re-sampled.
- start in the same cycle that done is asserted (state already IDLE): accepted normally; back-to-back ops allowed.
- Outputs y, y_hi, zero and div_by_zero hold their values between done pulses.
- y, y_hi and zero do not change while busy=1; partial results are kept in internal registers.
- Undefined alu_ctrl values: none exist (all 8 codes defined).

Optional Feature:
- Macro SEQ_ALU_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit), registered with y, reset 0.
  - ADD: ovf=1 when operand signs are equal and the result sign differs.
  - SUB: ovf=1 when operand signs differ and the result sign differs from a.
  - All other ops: ovf=0.
- When undefined: no ovf port and no overflow logic; port list is exactly as above.

Test Plan (WIDTH=32):
- Single-cycle ops, each a 1-cycle start pulse:
  - a=0x29, b=0x08, SUB -> next cycle y=0x21, zero=0, done=1.
  - a=b=0x08, SUB -> y=0, zero=1.
  - ADD 0x29+0x08 -> y=0x31.
- SLT vs SLTU:
  - a=0xFFFFFFFD, b=0xFFFFFFFB, SLT -> y=0; SLTU -> y=0.
  - a=0xFFFFFFFB, b=0xFFFFFFFD, SLT -> y=1.
  - a=0x1, b=0xFFFFFFFF, SLT -> y=0; SLTU -> y=1.
- MULU:
  - a=0xFFFFFFFF, b=0x2 -> busy=1 for 32 cycles; done at edge 33; y=0xFFFFFFFE, y_hi=0x1.
  - A start pulse during busy is ignored.
- DIVU:
  - a=100, b=7 -> done at edge 33; y=14, y_hi=2, div_by_zero=0.
  - Then b=0, a=0x55 -> next edge y=0xFFFFFFFF, y_hi=0x55, div_by_zero=1.
- Reset mid-operation:
  - Assert rst_n=0 at cycle 10 of a MULU -> all outputs 0 immediately (async).
  - After release, no done pulse; a fresh ADD completes normally.
- With SEQ_ALU_OVF_EN:
  - ADD 0x7FFFFFFF+1 -> y=0x80000000, ovf=1.
  - SUB 0x80000000-1 -> ovf=1.
  - ADD 1+1 -> ovf=0.
